// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 RGB window generator and the convolution stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_pkg;

  // Default colour channel width.
  localparam int PIX_W_DEFAULT = 8;

  // Channels per pixel and window geometry.
  localparam int N_CH     = 3;
  localparam int WIN_DIM  = 3;
  localparam int WIN_TAPS = WIN_DIM * WIN_DIM;

  // Channel slot inside a {R,G,B} pixel word; R occupies the MSBs.
  localparam int CH_B = 0;
  localparam int CH_G = 1;
  localparam int CH_R = 2;

  // Tap numbers (1..9, conv stage in_X_k) where a freshly accepted column enters the window.
  localparam int TAP_TOP_IN = 3;
  localparam int TAP_MID_IN = 6;
  localparam int TAP_BOT_IN = 9;

  // Tap k (1..9) occupies byte k-1 of a win_* bus.
  function automatic int tap_lsb(input int k, input int pix_w);
    return (k - 1) * pix_w;
  endfunction

  // LSB of channel slot ch inside a pixel word.
  function automatic int ch_lsb(input int ch, input int pix_w);
    return ch * pix_w;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle of the window generator.
// Latency: n/a (wiring only).
// Backpressure: pix_ready and win_ready carry the valid/ready handshakes.
interface conv_window_gen_if
  import conv_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEFAULT
);

  logic [N_CH*PIX_W-1:0]     pix_data;
  logic                      pix_sof;
  logic                      pix_valid;
  logic                      pix_ready;
  logic [WIN_TAPS*PIX_W-1:0] win_R;
  logic [WIN_TAPS*PIX_W-1:0] win_G;
  logic [WIN_TAPS*PIX_W-1:0] win_B;
  logic                      win_valid;
  logic                      win_last;
  logic                      win_ready;

  // Source of pixels and sink of windows (upstream + conv stage side).
  modport master (
    output pix_data, pix_sof, pix_valid, win_ready,
    input  pix_ready, win_R, win_G, win_B, win_valid, win_last
  );

  // The window generator itself.
  modport slave (
    input  pix_data, pix_sof, pix_valid, win_ready,
    output pix_ready, win_R, win_G, win_B, win_valid, win_last
  );

endinterface

// File: rtl/conv_line_buffer.sv
// Two-line pixel store: lb0 holds the previous line, lb1 the line before that.
// Latency: combinational read, write lands on the accepting clock edge.
// Backpressure: none; writes only when the caller signals an accepted pixel.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter  int IMG_W = 256,
  parameter  int DAT_W = N_CH * PIX_W_DEFAULT,
  localparam int AW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             wr_en,
  input  logic [DAT_W-1:0] wr_dat,
  output logic [DAT_W-1:0] top_dat,
  output logic [DAT_W-1:0] mid_dat
);

  // Storage is deliberately not reset: rows 0 and 1 of every frame rewrite it
  // before any window can use it.
  logic [DAT_W-1:0] lb0 [IMG_W];
  logic [DAT_W-1:0] lb1 [IMG_W];

  assign top_dat = lb1[addr];
  assign mid_dat = lb0[addr];

  // Age the column by one line on each accepted pixel.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= wr_dat;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Turns a raster RGB pixel stream into 3x3 RGB windows for interior pixels only.
// Latency: 1 cycle from accepting pixel (c>=2, r>=2) to win_valid.
// Backpressure: pix_ready = !win_valid || win_ready; a held window freezes the input.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input logic              clk,
  input logic              rstb,
  conv_window_gen_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DW = N_CH * PIX_W;
  localparam int WW = WIN_TAPS * PIX_W;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(WIN_DIM - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(WIN_DIM - 1);

  logic [CW-1:0] col_q;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] row_q;
  logic [RW-1:0] cur_row;

  logic          accept;
  logic          emit;
  logic          at_last;

  logic [DW-1:0] top_dat;
  logic [DW-1:0] mid_dat;

  // Per channel slot: running 3x3 window and the registered output copy.
  logic [WW-1:0] sh_q  [N_CH];
  logic [WW-1:0] sh_d  [N_CH];
  logic [WW-1:0] out_q [N_CH];

  logic          win_valid_q;
  logic          win_last_q;

  assign bus.pix_ready = !win_valid_q || bus.win_ready;
  assign accept        = bus.pix_valid && bus.pix_ready;

  // A start-of-frame pixel is (0,0) whatever the counters say.
  assign cur_col = bus.pix_sof ? '0 : col_q;
  assign cur_row = bus.pix_sof ? '0 : row_q;

  // Only interior positions produce a window.
  assign emit    = accept && (cur_col >= COL_MIN) && (cur_row >= ROW_MIN);
  assign at_last = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

  conv_line_buffer #(
    .IMG_W (IMG_W),
    .DAT_W (DW)
  ) u_line_buffer (
    .clk     (clk),
    .addr    (cur_col),
    .wr_en   (accept),
    .wr_dat  (bus.pix_data),
    .top_dat (top_dat),
    .mid_dat (mid_dat)
  );

  // Next window: every row shifts left, the new column enters taps 3/6/9.
  always_comb begin
    for (int s = 0; s < N_CH; s++) begin
      sh_d[s] = sh_q[s];
      if (accept) begin
        for (int r = 0; r < WIN_DIM; r++) begin
          for (int c = 1; c < WIN_DIM; c++) begin
            sh_d[s][tap_lsb(r*WIN_DIM + c, PIX_W) +: PIX_W] =
              sh_q[s][tap_lsb(r*WIN_DIM + c + 1, PIX_W) +: PIX_W];
          end
        end
        sh_d[s][tap_lsb(TAP_TOP_IN, PIX_W) +: PIX_W] = top_dat[ch_lsb(s, PIX_W) +: PIX_W];
        sh_d[s][tap_lsb(TAP_MID_IN, PIX_W) +: PIX_W] = mid_dat[ch_lsb(s, PIX_W) +: PIX_W];
        sh_d[s][tap_lsb(TAP_BOT_IN, PIX_W) +: PIX_W] = bus.pix_data[ch_lsb(s, PIX_W) +: PIX_W];
      end
    end
  end

  // Raster position counters, resynchronised by sof.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (cur_col == COL_LAST) begin
        col_q <= '0;
        row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_q <= cur_col + CW'(1);
        row_q <= cur_row;
      end
    end
  end

  // Window shift registers follow every accepted pixel.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int s = 0; s < N_CH; s++) begin
        sh_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < N_CH; s++) begin
        sh_q[s] <= sh_d[s];
      end
    end
  end

  // Output register and handshake: load on emit, drop valid once taken.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int s = 0; s < N_CH; s++) begin
        out_q[s] <= '0;
      end
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else if (emit) begin
      for (int s = 0; s < N_CH; s++) begin
        out_q[s] <= sh_d[s];
      end
      win_valid_q <= 1'b1;
      win_last_q  <= at_last;
    end else if (bus.win_ready) begin
      win_valid_q <= 1'b0;
    end
  end

  assign bus.win_R     = out_q[CH_R];
  assign bus.win_G     = out_q[CH_G];
  assign bus.win_B     = out_q[CH_B];
  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 4x4 instance for frame/handshake/reset cases
// and an 8x8 instance for streaming throughput, both scored against an image model.
module tb_conv_window_gen;
  import conv_pkg::*;

  typedef struct {
    logic [71:0] r;
    logic [71:0] g;
    logic [71:0] b;
    logic        last;
  } win_t;

  typedef struct {
    int         col;
    int         row;
    logic       sof;
    logic       exp_vld;
    logic       exp_last;
    logic [7:0] exp_ctr;
  } vec_t;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  conv_window_gen_if #(.PIX_W(8)) if4 ();
  conv_window_gen_if #(.PIX_W(8)) if8 ();

  conv_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut4 (
    .clk  (clk),
    .rstb (rstb),
    .bus  (if4.slave)
  );

  conv_window_gen #(.IMG_W(8), .IMG_H(8), .PIX_W(8)) dut8 (
    .clk  (clk),
    .rstb (rstb),
    .bus  (if8.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nwin [2];
  int mc   [2];
  int mr   [2];
  logic [23:0] img [2][8][8];
  win_t sbq0 [$];
  win_t sbq1 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int base, input int r, input int c);
    logic [7:0] v;
    v = 8'(base + 16*r + c);
    return {v, v + 8'd1, v + 8'd2};
  endfunction

  task automatic drive(input int d, input logic v, input logic sof, input logic [23:0] dat);
    if (d == 0) begin
      if4.pix_valid = v; if4.pix_sof = sof; if4.pix_data = dat;
    end else begin
      if8.pix_valid = v; if8.pix_sof = sof; if8.pix_data = dat;
    end
  endtask

  // Image model: remembers the frame as a 2D array and builds windows from it.
  task automatic model_accept(input int d, input logic [23:0] dat, input logic sof);
    int w, c, r;
    win_t e;
    logic [23:0] p;
    w = (d == 0) ? 4 : 8;
    c = sof ? 0 : mc[d];
    r = sof ? 0 : mr[d];
    img[d][r][c] = dat;
    if (c >= 2 && r >= 2) begin
      e.r = '0; e.g = '0; e.b = '0;
      for (int k = 0; k < 9; k++) begin
        p = img[d][r - 2 + k/3][c - 2 + k%3];
        e.r[k*8 +: 8] = p[23:16];
        e.g[k*8 +: 8] = p[15:8];
        e.b[k*8 +: 8] = p[7:0];
      end
      e.last = (c == w - 1) && (r == w - 1);
      if (d == 0) sbq0.push_back(e);
      else        sbq1.push_back(e);
    end
    if (c == w - 1) begin
      mc[d] = 0;
      mr[d] = (r == w - 1) ? 0 : r + 1;
    end else begin
      mc[d] = c + 1;
      mr[d] = r;
    end
  endtask

  // Call at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send_pix(input int d, input logic [23:0] dat, input logic sof);
    bit rdy;
    int n;
    rdy = 0;
    n   = 0;
    drive(d, 1'b1, sof, dat);
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = (d == 0) ? if4.pix_ready : if8.pix_ready;
      @(posedge clk);
      n++;
    end
    chk($sformatf("pix_accept_timeout_d%0d", d), 72'(rdy), 72'(1));
    if (rdy) model_accept(d, dat, sof);
    #1;
    drive(d, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic mon_cmp(input string tag, input win_t e, input logic [71:0] r,
                         input logic [71:0] g, input logic [71:0] b, input logic last);
    chk({tag, "_win_R"}, r, e.r);
    chk({tag, "_win_G"}, g, e.g);
    chk({tag, "_win_B"}, b, e.b);
    chk({tag, "_win_last"}, 72'(last), 72'(e.last));
  endtask

  // Scoreboards: pop one expected window per handshake.
  always @(negedge clk) begin
    if (rstb && if4.win_valid && if4.win_ready) begin
      nwin[0]++;
      chk("dut4_window_expected", 72'(sbq0.size() > 0), 72'(1));
      if (sbq0.size() > 0) mon_cmp("dut4", sbq0.pop_front(), if4.win_R, if4.win_G, if4.win_B, if4.win_last);
    end
  end

  always @(negedge clk) begin
    if (rstb && if8.win_valid && if8.win_ready) begin
      nwin[1]++;
      chk("dut8_window_expected", 72'(sbq1.size() > 0), 72'(1));
      if (sbq1.size() > 0) mon_cmp("dut8", sbq1.pop_front(), if8.win_R, if8.win_G, if8.win_B, if8.win_last);
    end
  end

  // One 4x4 frame from a vector table, checking win_valid one cycle after each pixel.
  task automatic run_frame4_table(input string tag);
    vec_t tbl [16];
    int   n0;
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{col: i % 4, row: i / 4, sof: (i == 0), exp_vld: 1'b0, exp_last: 1'b0, exp_ctr: 8'h00};
    end
    tbl[10].exp_vld = 1'b1; tbl[10].exp_ctr = 8'h11;
    tbl[11].exp_vld = 1'b1; tbl[11].exp_ctr = 8'h12;
    tbl[14].exp_vld = 1'b1; tbl[14].exp_ctr = 8'h21;
    tbl[15].exp_vld = 1'b1; tbl[15].exp_ctr = 8'h22; tbl[15].exp_last = 1'b1;
    n0 = nwin[0];
    for (int i = 0; i < 16; i++) begin
      send_pix(0, pix(0, tbl[i].row, tbl[i].col), tbl[i].sof);
      chk($sformatf("%s_vld_%0d", tag, i), 72'(if4.win_valid), 72'(tbl[i].exp_vld));
      if (tbl[i].exp_vld) begin
        chk($sformatf("%s_ctr_%0d", tag, i), 72'(if4.win_R[4*8 +: 8]), 72'(tbl[i].exp_ctr));
        chk($sformatf("%s_last_%0d", tag, i), 72'(if4.win_last), 72'(tbl[i].exp_last));
      end
      if (i == 10) begin
        chk({tag, "_first_R"}, if4.win_R, 72'h22_21_20_12_11_10_02_01_00);
        chk({tag, "_first_G"}, if4.win_G, 72'h23_22_21_13_12_11_03_02_01);
        chk({tag, "_first_B"}, if4.win_B, 72'h24_23_22_14_13_12_04_03_02);
      end
    end
    @(posedge clk); #1;
    chk({tag, "_win_count"}, 72'(nwin[0] - n0), 72'(4));
    chk({tag, "_queue_empty"}, 72'(sbq0.size()), 72'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [71:0] held_r;
    int n0, t0, tl, r, c;

    nwin[0] = 0; nwin[1] = 0;
    mc[0] = 0; mc[1] = 0; mr[0] = 0; mr[1] = 0;
    rstb = 1'b0;
    drive(0, 1'b0, 1'b0, 24'h0);
    drive(1, 1'b0, 1'b0, 24'h0);
    if4.win_ready = 1'b1;
    if8.win_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_win_valid", 72'(if4.win_valid), 72'(0));
    chk("rst_win_last", 72'(if4.win_last), 72'(0));
    chk("rst_win_R", if4.win_R, 72'h0);
    chk("rst_pix_ready", 72'(if4.pix_ready), 72'(1));
    chk("rst8_win_valid", 72'(if8.win_valid), 72'(0));
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;
    @(posedge clk); #1;

    // Basic 4x4 frame: latency, packing, window count, last flag
    run_frame4_table("s1");

    // Backpressure hold, frame started without sof after the wrap
    n0 = nwin[0];
    for (int i = 0; i < 11; i++) send_pix(0, pix(8'h40, i / 4, i % 4), 1'b0);
    if4.win_ready = 1'b0;
    held_r = if4.win_R;
    drive(0, 1'b1, 1'b0, pix(8'h40, 2, 3));
    repeat (5) begin
      @(negedge clk);
      chk("s3_pix_ready", 72'(if4.pix_ready), 72'(0));
      chk("s3_win_valid", 72'(if4.win_valid), 72'(1));
      chk("s3_win_R_stable", if4.win_R, held_r);
      chk("s3_win_last", 72'(if4.win_last), 72'(0));
    end
    @(posedge clk); #1;
    if4.win_ready = 1'b1;
    for (int i = 11; i < 16; i++) send_pix(0, pix(8'h40, i / 4, i % 4), 1'b0);
    @(posedge clk); #1;
    chk("s3_win_count", 72'(nwin[0] - n0), 72'(4));
    chk("s3_queue_empty", 72'(sbq0.size()), 72'(0));

    // Mid-frame sof at col 1, row 3
    n0 = nwin[0];
    for (int i = 0; i < 13; i++) send_pix(0, pix(8'h80, i / 4, i % 4), 1'b0);
    send_pix(0, pix(8'h08, 0, 0), 1'b1);
    chk("s5_no_window_at_sof", 72'(if4.win_valid), 72'(0));
    for (int i = 1; i < 16; i++) begin
      send_pix(0, pix(8'h08, i / 4, i % 4), 1'b0);
      if (i == 10) chk("s5_new_first_ctr", 72'(if4.win_R[4*8 +: 8]), 72'(8'h19));
    end
    @(posedge clk); #1;
    chk("s5_win_count", 72'(nwin[0] - n0), 72'(6));
    chk("s5_queue_empty", 72'(sbq0.size()), 72'(0));

    // Streaming 8x8 frame at full rate
    t0 = 0; tl = 0;
    for (int i = 0; i < 64; i++) begin
      r = i / 8; c = i % 8;
      send_pix(1, pix(0, r, c), i == 0);
      if (i == 0) t0 = cyc;
      tl = cyc;
      if (c >= 2 && r >= 2) chk($sformatf("s4_b2b_%0d", i), 72'(if8.win_valid), 72'(1));
    end
    @(posedge clk); #1;
    chk("s4_accept_span", 72'(tl - t0), 72'(63));
    chk("s4_win_count", 72'(nwin[1]), 72'(36));
    chk("s4_queue_empty", 72'(sbq1.size()), 72'(0));

    // Reset mid-row 2 with a window pending
    for (int i = 0; i < 11; i++) send_pix(0, pix(8'h80, i / 4, i % 4), 1'b0);
    chk("s6_pending", 72'(if4.win_valid), 72'(1));
    #2 rstb = 1'b0;
    #1;
    chk("s6_win_valid", 72'(if4.win_valid), 72'(0));
    chk("s6_win_R", if4.win_R, 72'h0);
    chk("s6_win_G", if4.win_G, 72'h0);
    chk("s6_win_B", if4.win_B, 72'h0);
    chk("s6_pix_ready", 72'(if4.pix_ready), 72'(1));
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    sbq0.delete();
    sbq1.delete();
    mc[0] = 0; mr[0] = 0; mc[1] = 0; mr[1] = 0;
    @(posedge clk); #1;
    run_frame4_table("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
